// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
// The mask helper is fixed at 32 bits, so patterns of up to 32 bits are supported.
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MASK_W = 32;

    // Ones in the low `len` positions. Bit 0 holds the newest history bit.
    function automatic logic [MASK_W-1:0] len_mask(input logic [MASK_W-1:0] len);
        logic [MASK_W-1:0] m;
        if (len >= MASK_W) begin
            m = '1;
        end else begin
            m = (MASK_W'(1) << len) - MASK_W'(1);
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear. When clear and increment
// arrive in the same cycle, the clear takes priority.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector. It supports an overlap mode,
// an input-valid qualifier and a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               clr_count,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    state_e state_q, state_d;

    logic [MAX_LEN-1:0] history_q, history_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    logic               overlap_q, overlap_d;
    logic               match_q,   match_d;
    logic               cfg_err_q, cfg_err_d;

    logic               cfg_legal;
    logic               accept;
    logic               hit;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_sat;
    logic [MASK_W-1:0]  mask;
    logic [MASK_W-1:0]  diff;

    assign cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    // A configuration load takes priority, so a bit arriving in the same cycle is dropped.
    assign accept     = (state_q == RUN) && in_valid && !cfg_load;
    assign hist_shift = {history_q[MAX_LEN-2:0], in_bit};
    assign fill_sat   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    assign mask       = len_mask(MASK_W'(len_q));
    assign diff       = MASK_W'(hist_shift ^ pattern_q) & mask;
    assign hit        = accept
                        && (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q})
                        && (diff == '0);

    // FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = cfg_legal ? RUN : IDLE;
        end
    end

    // FSM: output logic.
    always_comb begin
        armed = (state_q == RUN);
    end

    // History, fill and configuration next-state logic.
    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        cfg_err_d = cfg_err_q;
        match_d   = 1'b0;
        if (cfg_load) begin
            history_d = '0;
            fill_d    = '0;
            cfg_err_d = !cfg_legal;
            if (cfg_legal) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
            end
        end else if (accept) begin
            history_d = hist_shift;
            fill_d    = fill_sat;
            match_d   = hit;
            // In non-overlap mode, the next match must be built from entirely fresh bits.
            if (hit && !overlap_q) begin
                history_d = '0;
                fill_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_q <= '0;
            fill_q    <= '0;
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (clr_count | cfg_load),
        .q   (match_count)
    );

    assign match   = match_q;
    assign cfg_err = cfg_err_q;

endmodule
